// File: rtl/gf_field_arith_if.sv
// Operand/result bundle for one field-arithmetic lane.
// Multiply uses start/done strobes; add is strobe-free.
interface gf_field_arith_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] add_in_1;
  logic [WIDTH-1:0] add_in_2;
  logic [WIDTH-1:0] add_out;

  modport master (
    output start, in_1, in_2,
    output add_in_1, add_in_2,
    input  done, out, add_out
  );

  modport slave (
    input  start, in_1, in_2,
    input  add_in_1, add_in_2,
    output done, out, add_out
  );
endinterface

// File: rtl/gf_field_arith.sv
// Byte-lane field arithmetic: GF(2^8) (poly 0x11B) or integers mod 251.
// Latency-1 pipelined multiplier plus a field adder.
module gf_field_arith #(
  parameter string FIELD   = "P251",
  parameter int    WIDTH   = 8,
  parameter bit    REG_ADD = 1'b0
) (
  input logic          clk,
  input logic          rst,
  gf_field_arith_if.slave bus
);

  localparam bit IS_P = (FIELD == "P251");

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // Fold using 256 == 5 (mod 251) twice, then one final subtract.
  function automatic logic [7:0] p_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [15:0] p;
    logic [10:0] x;
    logic [8:0]  y;
    p = {8'h00, a} * {8'h00, b};
    x = 11'(p[15:8]) * 11'd5 + 11'(p[7:0]);
    y = 9'(x[10:8]) * 9'd5 + 9'(x[7:0]);
    if (y >= 9'd251) y = y - 9'd251;
    return y[7:0];
  endfunction

  function automatic logic [7:0] p_add(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 9'd251) s = s - 9'd251;
    if (s >= 9'd251) s = s - 9'd251;
    return s[7:0];
  endfunction

  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] sum;
  logic             done_q;
  logic [WIDTH-1:0] out_q;

  always_comb begin
    prod = '0;
    sum  = '0;
    if (IS_P) begin
      prod = p_mul(bus.in_1, bus.in_2);
      sum  = p_add(bus.add_in_1, bus.add_in_2);
    end else begin
      prod = gf_mul(bus.in_1, bus.in_2);
      sum  = bus.add_in_1 ^ bus.add_in_2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      out_q  <= '0;
    end else begin
      done_q <= bus.start;
      if (bus.start) out_q <= prod;
    end
  end

  assign bus.done = done_q;
  assign bus.out  = out_q;

  generate
    if (REG_ADD) begin : g_add_reg
      logic [WIDTH-1:0] add_q;
      always_ff @(posedge clk) begin
        if (rst) add_q <= '0;
        else     add_q <= sum;
      end
      assign bus.add_out = add_q;
    end else begin : g_add_comb
      assign bus.add_out = sum;
    end
  endgenerate

endmodule

// File: tb/tb_gf_field_arith.sv
// Scoreboard bench: P251 lane (combinational add) and GF256 lane
// (registered add) driven side by side.
module tb_gf_field_arith;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf_field_arith_if bp ();
  gf_field_arith_if bg ();

  gf_field_arith #(
    .FIELD("P251"), .WIDTH(8), .REG_ADD(1'b0)
  ) u_p (
    .clk(clk), .rst(rst), .bus(bp.slave)
  );

  gf_field_arith #(
    .FIELD("GF256"), .WIDTH(8), .REG_ADD(1'b1)
  ) u_g (
    .clk(clk), .rst(rst), .bus(bg.slave)
  );

  int nvec = 0;
  int nerr = 0;
  bit mon_en = 1'b0;
  logic [7:0] qp[$];
  logic [7:0] qg[$];
  logic [7:0] g_prev;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(string name, logic act, logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_gf(logic [7:0] a, logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] m_p(logic [7:0] a, logic [7:0] b);
    int r;
    r = (int'(a) * int'(b)) % 251;
    return 8'(r);
  endfunction

  function automatic logic [7:0] m_padd(logic [7:0] a, logic [7:0] b);
    int r;
    r = (int'(a) + int'(b)) % 251;
    return 8'(r);
  endfunction

  // Monitor: pops an expected product whenever a lane presents done.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bp.done === 1'b1) begin
        if (qp.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL p_spurious_done: got done=1 want done=0");
        end else begin
          chk("p_mul", bp.out, qp.pop_front());
        end
      end else if (bp.done !== 1'b0) begin
        chk_bit("p_done_known", bp.done, 1'b0);
      end
      if (bg.done === 1'b1) begin
        if (qg.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL g_spurious_done: got done=1 want done=0");
        end else begin
          chk("g_mul", bg.out, qg.pop_front());
        end
      end else if (bg.done !== 1'b0) begin
        chk_bit("g_done_known", bg.done, 1'b0);
      end
    end
  end

  task automatic issue(
    bit sp, logic [7:0] pa, logic [7:0] pb, logic [7:0] pe,
    bit sg, logic [7:0] ga, logic [7:0] gb, logic [7:0] ge
  );
    @(posedge clk); #1;
    bp.start = sp; bp.in_1 = pa; bp.in_2 = pb;
    bg.start = sg; bg.in_1 = ga; bg.in_2 = gb;
    if (sp && !rst) qp.push_back(pe);
    if (sg && !rst) qg.push_back(ge);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      issue(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic p_add_chk(logic [7:0] a, logic [7:0] b, logic [7:0] e);
    bp.add_in_1 = a; bp.add_in_2 = b;
    #1;
    chk("p_add", bp.add_out, e);
  endtask

  task automatic g_add_chk(logic [7:0] a, logic [7:0] b, logic [7:0] e);
    @(posedge clk); #1;
    bg.add_in_1 = a; bg.add_in_2 = b;
    @(negedge clk);
    chk("g_add_hold", bg.add_out, g_prev);
    @(posedge clk); #1;
    chk("g_add", bg.add_out, e);
    g_prev = e;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e;
  } vec_t;

  vec_t pv[$];
  vec_t gv[$];

  initial begin
    bp.start = 0; bp.in_1 = 0; bp.in_2 = 0;
    bp.add_in_1 = 0; bp.add_in_2 = 0;
    bg.start = 0; bg.in_1 = 0; bg.in_2 = 0;
    bg.add_in_1 = 8'h5A; bg.add_in_2 = 8'h00;

    pv = '{'{8'd250, 8'd250, 8'd1}, '{8'd17, 8'd15, 8'd4},
           '{8'd0, 8'd200, 8'd0},   '{8'd1, 8'd250, 8'd250},
           '{8'd255, 8'd1, 8'd4},   '{8'd251, 8'd1, 8'd0},
           '{8'h57, 8'h83, 8'd102}};
    gv = '{'{8'h57, 8'h83, 8'hC1}, '{8'h53, 8'hCA, 8'h01},
           '{8'h57, 8'h13, 8'hFE}, '{8'h57, 8'h02, 8'hAE},
           '{8'h00, 8'h55, 8'h00}, '{8'h01, 8'hAB, 8'hAB},
           '{8'h02, 8'h80, 8'h1B}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_bit("rst_p_done", bp.done, 1'b0);
    chk("rst_p_out", bp.out, 8'h00);
    chk_bit("rst_g_done", bg.done, 1'b0);
    chk("rst_g_out", bg.out, 8'h00);
    chk("rst_g_add", bg.add_out, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    g_prev = 8'h5A;

    // Isolated directed products, one per cycle with gaps.
    for (int i = 0; i < 7; i++) begin
      issue(1'b1, pv[i].a, pv[i].b, pv[i].e,
            1'b1, gv[i].a, gv[i].b, gv[i].e);
      idle(1);
      @(negedge clk);
      chk("p_out_hold", bp.out, pv[i].e);
    end

    // Back-to-back stream on the P251 lane.
    issue(1'b1, 8'd2,   8'd3,   8'd6,   1'b0, 8'h00, 8'h00, 8'h00);
    issue(1'b1, 8'd10,  8'd30,  8'd49,  1'b0, 8'h00, 8'h00, 8'h00);
    issue(1'b1, 8'd100, 8'd100, 8'd211, 1'b0, 8'h00, 8'h00, 8'h00);
    issue(1'b1, 8'd250, 8'd2,   8'd249, 1'b0, 8'h00, 8'h00, 8'h00);
    idle(3);

    p_add_chk(8'd200, 8'd100, 8'd49);
    p_add_chk(8'd250, 8'd1,   8'd0);
    p_add_chk(8'd125, 8'd125, 8'd250);
    p_add_chk(8'd255, 8'd255, 8'd8);
    p_add_chk(8'd251, 8'd0,   8'd0);
    p_add_chk(8'd3,   8'd4,   8'd7);
    g_add_chk(8'h53, 8'hCA, 8'h99);
    g_add_chk(8'hFF, 8'hFF, 8'h00);
    g_add_chk(8'h00, 8'h5A, 8'h5A);

    // Reset lands while a stream is running.
    issue(1'b1, 8'd2, 8'd3, 8'd6, 1'b1, 8'h57, 8'h83, 8'hC1);
    @(posedge clk); #1;
    rst = 1'b1;
    bp.in_1 = 8'd10; bp.in_2 = 8'd30;
    bg.in_1 = 8'h53; bg.in_2 = 8'hCA;
    @(posedge clk);
    @(negedge clk);
    chk_bit("mid_rst_p_done", bp.done, 1'b0);
    chk("mid_rst_p_out", bp.out, 8'h00);
    chk_bit("mid_rst_g_done", bg.done, 1'b0);
    chk("mid_rst_g_out", bg.out, 8'h00);
    chk("mid_rst_g_add", bg.add_out, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    bp.start = 1'b0; bg.start = 1'b0;
    g_prev = 8'h5A;
    idle(4);

    // Random sweep against independent software models.
    for (int i = 0; i < 500; i++) begin
      logic [7:0] a, b, c, d;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      c = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      issue(1'b1, a, b, m_p(a, b), 1'b1, c, d, m_gf(c, d));
      p_add_chk(c, a, m_padd(c, a));
    end
    idle(3);

    chk("p_queue_drained", 8'(qp.size()), 8'd0);
    chk("g_queue_drained", 8'(qg.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
